// File: rtl/add_txn_initiator_if.sv
// Bundle of the host request/response channels and the adder start/valid bus
// seen by the transaction initiator.
interface add_txn_initiator_if #(
  parameter int W  = 10,
  parameter int CW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;

  logic          dut_start;
  logic [W-1:0]  dut_a;
  logic [W-1:0]  dut_b;
  logic [W-1:0]  dut_y;
  logic          dut_valid;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_y;
  logic          rsp_data_err;
  logic          rsp_lat_err;
  logic          rsp_timeout;
  logic [CW-1:0] rsp_lat;
  logic [7:0]    err_count;
  logic          spurious;

  // Initiator side
  modport master (
    input  req_valid, req_a, req_b, dut_y, dut_valid, rsp_ready,
    output req_ready, dut_start, dut_a, dut_b,
    output rsp_valid, rsp_y, rsp_data_err, rsp_lat_err, rsp_timeout, rsp_lat,
    output err_count, spurious
  );

  // Host + adder side
  modport slave (
    output req_valid, req_a, req_b, dut_y, dut_valid, rsp_ready,
    input  req_ready, dut_start, dut_a, dut_b,
    input  rsp_valid, rsp_y, rsp_data_err, rsp_lat_err, rsp_timeout, rsp_lat,
    input  err_count, spurious
  );
endinterface

// File: rtl/add_txn_initiator.sv
// Issues host operand pairs to a start/valid adder, checks result value and
// latency, and returns one response per transaction with running error stats.
module add_txn_initiator #(
  parameter int W       = 10,
  parameter int EXP_LAT = 2,
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  add_txn_initiator_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  exp_q;
  logic [CW-1:0] lat_cnt;
  logic          start_q;
  logic          rsp_valid_q;
  logic [W-1:0]  rsp_y_q;
  logic          rsp_data_err_q;
  logic          rsp_lat_err_q;
  logic          rsp_timeout_q;
  logic [CW-1:0] rsp_lat_q;
  logic [7:0]    err_count_q;
  logic          spurious_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      exp_q          <= '0;
      lat_cnt        <= '0;
      start_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_y_q        <= '0;
      rsp_data_err_q <= 1'b0;
      rsp_lat_err_q  <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_lat_q      <= '0;
      err_count_q    <= '0;
      spurious_q     <= 1'b0;
    end else begin
      // A result outside WAIT is never consumed, only flagged.
      if (bus.dut_valid && state != S_WAIT)
        spurious_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            exp_q   <= bus.req_a + bus.req_b;
            start_q <= 1'b1;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          start_q <= 1'b0;
          lat_cnt <= CW'(1);
          state   <= S_WAIT;
        end

        S_WAIT: begin
          // A valid on the final counted cycle still wins over the timeout.
          if (bus.dut_valid) begin
            rsp_y_q        <= bus.dut_y;
            rsp_lat_q      <= lat_cnt;
            rsp_data_err_q <= (bus.dut_y != exp_q);
            rsp_lat_err_q  <= (lat_cnt != CW'(EXP_LAT));
            rsp_timeout_q  <= 1'b0;
            rsp_valid_q    <= 1'b1;
            state          <= S_RESP;
          end else if (lat_cnt == CW'(TIMEOUT)) begin
            rsp_y_q        <= '0;
            rsp_lat_q      <= CW'(TIMEOUT);
            rsp_data_err_q <= 1'b0;
            rsp_lat_err_q  <= 1'b1;
            rsp_timeout_q  <= 1'b1;
            rsp_valid_q    <= 1'b1;
            state          <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if ((rsp_data_err_q || rsp_lat_err_q || rsp_timeout_q) && err_count_q != 8'hFF)
              err_count_q <= err_count_q + 8'd1;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.dut_start    = start_q;
  assign bus.dut_a        = a_q;
  assign bus.dut_b        = b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_data_err = rsp_data_err_q;
  assign bus.rsp_lat_err  = rsp_lat_err_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.rsp_lat      = rsp_lat_q;
  assign bus.err_count    = err_count_q;
  assign bus.spurious     = spurious_q;

endmodule

// File: tb/tb_add_txn_initiator.sv
// Directed bench: a configurable start/valid adder model drives the initiator,
// each scenario task checks its own expected values.
module tb_add_txn_initiator;

  localparam int W  = 10;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_txn_initiator_if #(.W(W), .CW(CW)) bus ();

  add_txn_initiator #(.W(W), .EXP_LAT(2), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Adder model knobs
  int       model_lat = 2;
  int       model_err = 0;
  bit       model_off = 0;
  bit       inject    = 0;
  logic     m_act;
  logic [7:0] m_cnt;
  logic     model_valid;
  logic [W-1:0] sum_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_cnt <= 8'd0;
    end else if (bus.dut_start) begin
      m_act <= 1'b1;
      m_cnt <= 8'd1;
    end else if (m_act) begin
      if (m_cnt == 8'(model_lat)) m_act <= 1'b0;
      else m_cnt <= m_cnt + 8'd1;
    end
  end

  assign model_valid   = m_act && (m_cnt == 8'(model_lat)) && !model_off;
  assign sum_v         = bus.dut_a + bus.dut_b + W'(model_err);
  assign bus.dut_valid = model_valid || inject;
  assign bus.dut_y     = model_valid ? sum_v : 10'h3FF;

  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    ok = 0;
    @(negedge clk);
    bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic accept_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.dut_start !== 1'b0 || bus.dut_a !== 10'd0 || bus.dut_b !== 10'd0) begin bad++; $display("FAIL reset_dut: start=%b a=%0d b=%0d want 0", bus.dut_start, bus.dut_a, bus.dut_b); end
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 10'd0 || bus.rsp_lat !== 5'd0) begin bad++; $display("FAIL reset_rsp: valid=%b y=%0d lat=%0d want 0", bus.rsp_valid, bus.rsp_y, bus.rsp_lat); end
    total++; if (bus.err_count !== 8'd0 || bus.spurious !== 1'b0) begin bad++; $display("FAIL reset_stats: err=%0d spur=%b want 0", bus.err_count, bus.spurious); end
    rst_n = 1'b1;
    $display("txn reset: released");
  endtask

  task automatic test_basic();
    bit ok;
    send_req(10'd100, 10'd200, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_accept: got timeout want handshake"); end
    total++; if (bus.dut_start !== 1'b1 || bus.dut_a !== 10'd100 || bus.dut_b !== 10'd200) begin bad++; $display("FAIL basic_issue: start=%b a=%0d b=%0d want 1/100/200", bus.dut_start, bus.dut_a, bus.dut_b); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_issue: got %b want 0", bus.req_ready); end
    @(negedge clk);
    total++; if (bus.dut_start !== 1'b0 || bus.dut_a !== 10'd100 || bus.dut_b !== 10'd200) begin bad++; $display("FAIL basic_hold: start=%b a=%0d b=%0d want 0/100/200", bus.dut_start, bus.dut_a, bus.dut_b); end
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_rsp_wait: got no rsp_valid want rsp_valid"); end
    total++; if (bus.rsp_y !== 10'd300 || bus.rsp_lat !== 5'd2) begin bad++; $display("FAIL basic_rsp: y=%0d lat=%0d want 300/2", bus.rsp_y, bus.rsp_lat); end
    total++; if ({bus.rsp_data_err, bus.rsp_lat_err, bus.rsp_timeout} !== 3'b000) begin bad++; $display("FAIL basic_flags: got %b want 000", {bus.rsp_data_err, bus.rsp_lat_err, bus.rsp_timeout}); end
    accept_rsp();
    total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.err_count !== 8'd0) begin bad++; $display("FAIL basic_done: valid=%b ready=%b err=%0d want 0/1/0", bus.rsp_valid, bus.req_ready, bus.err_count); end
    $display("txn basic: a=100 b=200 y=%0d lat=%0d", bus.rsp_y, bus.rsp_lat);
  endtask

  task automatic test_wrap();
    bit ok;
    send_req(10'd1000, 10'd50, ok);
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_rsp_wait: got no rsp_valid want rsp_valid"); end
    total++; if (bus.rsp_y !== 10'd26 || bus.rsp_data_err !== 1'b0) begin bad++; $display("FAIL wrap_rsp: y=%0d derr=%b want 26/0", bus.rsp_y, bus.rsp_data_err); end
    accept_rsp();
    $display("txn wrap: a=1000 b=50 y=%0d", bus.rsp_y);
  endtask

  task automatic test_errors();
    bit ok;
    model_err = 1;
    send_req(10'd100, 10'd200, ok);
    wait_rsp(ok);
    total++; if (bus.rsp_y !== 10'd301 || bus.rsp_data_err !== 1'b1 || bus.rsp_lat_err !== 1'b0) begin bad++; $display("FAIL data_err_rsp: y=%0d derr=%b lerr=%b want 301/1/0", bus.rsp_y, bus.rsp_data_err, bus.rsp_lat_err); end
    accept_rsp();
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL data_err_count: got %0d want 1", bus.err_count); end
    $display("txn data_err: y=%0d err_count=%0d", bus.rsp_y, bus.err_count);
    model_err = 0; model_lat = 3;
    send_req(10'd100, 10'd200, ok);
    wait_rsp(ok);
    total++; if (bus.rsp_lat !== 5'd3 || bus.rsp_lat_err !== 1'b1 || bus.rsp_data_err !== 1'b0 || bus.rsp_y !== 10'd300) begin bad++; $display("FAIL lat_err_rsp: lat=%0d lerr=%b derr=%b y=%0d want 3/1/0/300", bus.rsp_lat, bus.rsp_lat_err, bus.rsp_data_err, bus.rsp_y); end
    accept_rsp();
    total++; if (bus.err_count !== 8'd2) begin bad++; $display("FAIL lat_err_count: got %0d want 2", bus.err_count); end
    $display("txn lat_err: lat=%0d err_count=%0d", bus.rsp_lat, bus.err_count);
    model_lat = 2;
  endtask

  task automatic test_timeout();
    bit ok;
    model_off = 1;
    send_req(10'd1, 10'd2, ok);
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_wait: got no rsp_valid want rsp_valid"); end
    total++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_lat !== 5'd16 || bus.rsp_y !== 10'd0) begin bad++; $display("FAIL timeout_rsp: to=%b lat=%0d y=%0d want 1/16/0", bus.rsp_timeout, bus.rsp_lat, bus.rsp_y); end
    total++; if (bus.rsp_lat_err !== 1'b1 || bus.rsp_data_err !== 1'b0) begin bad++; $display("FAIL timeout_flags: lerr=%b derr=%b want 1/0", bus.rsp_lat_err, bus.rsp_data_err); end
    accept_rsp();
    total++; if (bus.err_count !== 8'd3) begin bad++; $display("FAIL timeout_count: got %0d want 3", bus.err_count); end
    $display("txn timeout: lat=%0d err_count=%0d", bus.rsp_lat, bus.err_count);
    model_off = 0;
    send_req(10'd5, 10'd6, ok);
    wait_rsp(ok);
    total++; if (bus.rsp_y !== 10'd11 || bus.rsp_timeout !== 1'b0 || bus.rsp_lat !== 5'd2) begin bad++; $display("FAIL after_timeout: y=%0d to=%b lat=%0d want 11/0/2", bus.rsp_y, bus.rsp_timeout, bus.rsp_lat); end
    accept_rsp();
    $display("txn after_timeout: y=%0d", bus.rsp_y);
  endtask

  task automatic test_backpressure();
    bit ok;
    send_req(10'd7, 10'd8, ok);
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_wait: got no rsp_valid want rsp_valid"); end
    bus.req_a = 10'd500; bus.req_b = 10'd500; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inject = (i == 2);
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 10'd15 || bus.rsp_lat !== 5'd2 || bus.rsp_data_err !== 1'b0) begin bad++; $display("FAIL bp_hold%0d: valid=%b y=%0d lat=%0d derr=%b want 1/15/2/0", i, bus.rsp_valid, bus.rsp_y, bus.rsp_lat, bus.rsp_data_err); end
      total++; if (bus.req_ready !== 1'b0 || bus.dut_a !== 10'd7) begin bad++; $display("FAIL bp_req%0d: ready=%b a=%0d want 0/7", i, bus.req_ready, bus.dut_a); end
    end
    inject = 0;
    bus.req_valid = 1'b0;
    total++; if (bus.spurious !== 1'b1) begin bad++; $display("FAIL bp_spurious: got %b want 1", bus.spurious); end
    accept_rsp();
    $display("txn backpressure: y=%0d spurious=%b", bus.rsp_y, bus.spurious);
  endtask

  task automatic test_async_reset();
    bit seen;
    bit ok;
    send_req(10'd3, 10'd4, ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.dut_a !== 10'd0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL areset_now: a=%0d valid=%b ready=%b want 0/0/1", bus.dut_a, bus.rsp_valid, bus.req_ready); end
    total++; if (bus.err_count !== 8'd0 || bus.spurious !== 1'b0 || bus.dut_start !== 1'b0) begin bad++; $display("FAIL areset_stats: err=%0d spur=%b start=%b want 0", bus.err_count, bus.spurious, bus.dut_start); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    total++; if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL areset_after: rsp_seen=%b ready=%b want 0/1", seen, bus.req_ready); end
    $display("txn async_reset: dropped in-flight 3+4");
  endtask

  task automatic test_saturate();
    bit ok;
    int lost = 0;
    model_err = 1;
    for (int i = 1; i <= 260; i++) begin
      send_req(10'(i), 10'd9, ok);
      wait_rsp(ok);
      if (!ok) lost++;
      accept_rsp();
      if (i == 254) begin
        total++; if (bus.err_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", bus.err_count); end
      end
    end
    model_err = 0;
    total++; if (lost != 0) begin bad++; $display("FAIL sat_lost: got %0d missing responses want 0", lost); end
    total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_final: got %0d want 255", bus.err_count); end
    $display("txn saturate: 260 errored txns err_count=%0d", bus.err_count);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_errors();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
